// File: rtl/jtopl_eg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : jtopl_eg_pipe
//  Purpose  : Per-slot envelope state storage for the OPL envelope generator.
//             Holds {phase, attenuation, last key} for every slot in a
//             circular shift register and presents the head slot, key edges
//             and the global envelope counter to the envelope stages.
//  Revision : 1.0  initial release
// ============================================================================
module jtopl_eg_pipe #(
    parameter int SLOTS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        keyon,
    input  logic [2:0]  state_next,
    input  logic [9:0]  eg_next,
    output logic        keyon_now,
    output logic        keyoff_now,
    output logic [2:0]  state_cur,
    output logic [9:0]  eg_cur,
    output logic [4:0]  slot,
    output logic        zero,
    output logic [14:0] eg_cnt
);

    localparam logic [2:0] c_ST_RELEASE = 3'b100;
    localparam logic [9:0] c_EG_MAX     = 10'h3FF;
    localparam logic [4:0] c_LAST_SLOT  = 5'(SLOTS - 1);

    // Entry 0 is the head (slot being processed), entry SLOTS-1 the tail.
    logic [2:0]  state_q [SLOTS];
    logic [9:0]  eg_q    [SLOTS];
    logic        kon_q   [SLOTS];

    logic [4:0]  slot_q;
    logic [4:0]  slot_d;
    logic        zero_q;
    logic [14:0] cnt_q;
    logic [14:0] cnt_d;
    logic        w_last;

    // Storage shift register: each entry moves one step toward the head,
    // the tail captures the freshly computed values for the retiring slot.
    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_entry
            if (i == SLOTS - 1) begin : g_tail
                // Tail entry loads the write-back values of the head slot
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        state_q[i] <= c_ST_RELEASE;
                        eg_q[i]    <= c_EG_MAX;
                        kon_q[i]   <= 1'b0;
                    end else if (cen) begin
                        state_q[i] <= state_next;
                        eg_q[i]    <= eg_next;
                        kon_q[i]   <= keyon;
                    end
                end
            end else begin : g_body
                // Body entries take the value of their upstream neighbour
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        state_q[i] <= c_ST_RELEASE;
                        eg_q[i]    <= c_EG_MAX;
                        kon_q[i]   <= 1'b0;
                    end else if (cen) begin
                        state_q[i] <= state_q[i+1];
                        eg_q[i]    <= eg_q[i+1];
                        kon_q[i]   <= kon_q[i+1];
                    end
                end
            end
        end
    endgenerate

    // Slot index wraps at the last slot; the envelope counter advances once
    // per full round, on the same edge as the slot wrap.
    always_comb begin
        w_last = (slot_q == c_LAST_SLOT);
        slot_d = w_last ? 5'd0 : slot_q + 5'd1;
        cnt_d  = w_last ? cnt_q + 15'd1 : cnt_q;
    end

    // Slot sequencer and global envelope counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 5'd0;
            zero_q <= 1'b1;
            cnt_q  <= 15'd0;
        end else if (cen) begin
            slot_q <= slot_d;
            zero_q <= w_last;
            cnt_q  <= cnt_d;
        end
    end

    assign state_cur  = state_q[0];
    assign eg_cur     = eg_q[0];
    assign slot       = slot_q;
    assign zero       = zero_q;
    assign eg_cnt     = cnt_q;
    assign keyon_now  = keyon & ~kon_q[0];
    assign keyoff_now = ~keyon & kon_q[0];

endmodule
`default_nettype wire

// File: tb/tb_jtopl_eg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtopl_eg_pipe
//  Purpose  : Self-checking bench for jtopl_eg_pipe. A slot-indexed model
//             (one array entry per slot number) predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtopl_eg_pipe;

    localparam int SLOTS = 18;

    logic        clk = 1'b0;
    logic        rst_n, cen, keyon;
    logic [2:0]  state_next;
    logic [9:0]  eg_next;
    logic        keyon_now, keyoff_now, zero;
    logic [2:0]  state_cur;
    logic [9:0]  eg_cur;
    logic [4:0]  slot;
    logic [14:0] eg_cnt;

    // Second, minimum-size instance used to reach the eg_cnt wrap quickly
    logic        rst2_n, cen2, keyon2;
    logic [2:0]  state_next2, state_cur2;
    logic [9:0]  eg_next2, eg_cur2;
    logic        keyon_now2, keyoff_now2, zero2;
    logic [4:0]  slot2;
    logic [14:0] eg_cnt2;
    bit          done2 = 1'b0;

    always #5 clk = ~clk;

    jtopl_eg_pipe #(.SLOTS(SLOTS)) u_dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .keyon(keyon),
        .state_next(state_next), .eg_next(eg_next),
        .keyon_now(keyon_now), .keyoff_now(keyoff_now),
        .state_cur(state_cur), .eg_cur(eg_cur), .slot(slot),
        .zero(zero), .eg_cnt(eg_cnt)
    );

    assign state_next2 = state_cur2;
    assign eg_next2    = eg_cur2;

    jtopl_eg_pipe #(.SLOTS(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .cen(cen2), .keyon(keyon2),
        .state_next(state_next2), .eg_next(eg_next2),
        .keyon_now(keyon_now2), .keyoff_now(keyoff_now2),
        .state_cur(state_cur2), .eg_cur(eg_cur2), .slot(slot2),
        .zero(zero2), .eg_cnt(eg_cnt2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: per-slot records addressed by slot number
    logic [2:0] m_st  [SLOTS];
    logic [9:0] m_eg  [SLOTS];
    bit         m_kon [SLOTS];
    int         m_slot;
    int         m_cnt;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_st[i]  = 3'b100;
            m_eg[i]  = 10'h3FF;
            m_kon[i] = 1'b0;
        end
        m_slot = 0;
        m_cnt  = 0;
    endtask

    // Drive inputs and compare all outputs against the model
    task automatic apply(input bit c, input bit k, input logic [2:0] sn, input logic [9:0] en);
        cen = c; keyon = k; state_next = sn; eg_next = en;
        #1;
        check("slot",       slot,       m_slot);
        check("zero",       zero,       (m_slot == 0));
        check("eg_cnt",     eg_cnt,     m_cnt);
        check("state_cur",  state_cur,  m_st[m_slot]);
        check("eg_cur",     eg_cur,     m_eg[m_slot]);
        check("keyon_now",  keyon_now,  k & ~m_kon[m_slot]);
        check("keyoff_now", keyoff_now, ~k & m_kon[m_slot]);
    endtask

    // Clock edge; the model records the write for the current slot
    task automatic commit();
        @(posedge clk);
        if (cen) begin
            m_st[m_slot]  = state_next;
            m_eg[m_slot]  = eg_next;
            m_kon[m_slot] = keyon;
            if (m_slot == SLOTS - 1) begin
                m_slot = 0;
                m_cnt  = (m_cnt + 1) % 32768;
            end else begin
                m_slot = m_slot + 1;
            end
        end
        #1;
    endtask

    task automatic tick(input bit c, input bit k, input logic [2:0] sn, input logic [9:0] en);
        apply(c, k, sn, en);
        commit();
    endtask

    task automatic hold(input bit c);
        tick(c, m_kon[m_slot], m_st[m_slot], m_eg[m_slot]);
    endtask

    task automatic goto_slot(input int s);
        while (m_slot != s) hold(1'b1);
    endtask

    typedef struct {
        bit         k;
        logic [2:0] sn;
        logic [9:0] en;
        bit         exp_on;
        bit         exp_off;
        logic [2:0] exp_st;
        logic [9:0] exp_eg;
    } visit_t;

    visit_t vt [4];

    initial begin
        int zc;
        int saved_cnt;

        vt[0] = '{k:1'b1, sn:3'b001, en:10'h100, exp_on:1'b1, exp_off:1'b0, exp_st:3'b100, exp_eg:10'h3FF};
        vt[1] = '{k:1'b1, sn:3'b010, en:10'h080, exp_on:1'b0, exp_off:1'b0, exp_st:3'b001, exp_eg:10'h100};
        vt[2] = '{k:1'b0, sn:3'b100, en:10'h080, exp_on:1'b0, exp_off:1'b1, exp_st:3'b010, exp_eg:10'h080};
        vt[3] = '{k:1'b0, sn:3'b100, en:10'h3FF, exp_on:1'b0, exp_off:1'b0, exp_st:3'b100, exp_eg:10'h080};

        rst_n = 1'b1; cen = 1'b0; keyon = 1'b0; state_next = 3'b0; eg_next = 10'h0;

        // Asynchronous reset taking effect without a clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        keyon = 1'b1;
        #1;
        check("rst_state_cur",  state_cur,  3'b100);
        check("rst_eg_cur",     eg_cur,     10'h3FF);
        check("rst_slot",       slot,       5'd0);
        check("rst_zero",       zero,       1'b1);
        check("rst_eg_cnt",     eg_cnt,     15'd0);
        check("rst_keyoff_now", keyoff_now, 1'b0);
        check("rst_keyon_now",  keyon_now,  1'b1);
        keyon = 1'b0;
        #1;
        check("rst_keyon_now0", keyon_now,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Counter over five full rounds from reset
        zc = 0;
        for (int i = 0; i < 90; i++) begin
            apply(1'b1, m_kon[m_slot], m_st[m_slot], m_eg[m_slot]);
            if (zero) zc++;
            commit();
        end
        check("cnt_after_90", eg_cnt, 15'd5);
        check("zero_count",   zc + int'(zero), 6);

        // Key edges on slot 5 across four visits
        for (int v = 0; v < 4; v++) begin
            goto_slot(5);
            apply(1'b1, vt[v].k, vt[v].sn, vt[v].en);
            check("visit_keyon_now",  keyon_now,  vt[v].exp_on);
            check("visit_keyoff_now", keyoff_now, vt[v].exp_off);
            check("visit_state_cur",  state_cur,  vt[v].exp_st);
            check("visit_eg_cur",     eg_cur,     vt[v].exp_eg);
            commit();
        end

        // Write-back latency on adjacent slots 7 and 8
        goto_slot(7);
        tick(1'b1, m_kon[7], m_st[7], 10'h155);
        tick(1'b1, m_kon[8], m_st[8], 10'h2AA);
        goto_slot(6);
        apply(1'b1, m_kon[6], m_st[6], m_eg[6]);
        check("wb_slot6", eg_cur, 10'h3FF);
        commit();
        apply(1'b1, m_kon[7], m_st[7], m_eg[7]);
        check("wb_slot7", eg_cur, 10'h155);
        commit();
        apply(1'b1, m_kon[8], m_st[8], m_eg[8]);
        check("wb_slot8", eg_cur, 10'h2AA);
        commit();
        apply(1'b1, m_kon[9], m_st[9], m_eg[9]);
        check("wb_slot9", eg_cur, 10'h3FF);
        commit();

        // Clock enable held low with changing inputs
        goto_slot(11);
        saved_cnt = m_cnt;
        for (int i = 0; i < 100; i++)
            tick(1'b0, 1'($urandom), 3'($urandom), 10'($urandom));
        check("cen_slot_hold", slot,   5'd11);
        check("cen_cnt_hold",  eg_cnt, saved_cnt);
        for (int i = 0; i < SLOTS; i++) hold(1'b1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 10'($urandom));

        // Reset pulse mid-operation after loading every slot
        for (int i = 0; i < SLOTS; i++)
            tick(1'b1, 1'b1, 3'b010, 10'($urandom_range(0, 1022)));
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            apply(1'b1, 1'b0, 3'b100, 10'h3FF);
            check("mrst_state", state_cur,  3'b100);
            check("mrst_eg",    eg_cur,     10'h3FF);
            check("mrst_koff",  keyoff_now, 1'b0);
            commit();
        end

        wait (done2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // eg_cnt wrap on the two-slot instance: after n edges, slot=n%2 and
    // eg_cnt=(n/2) mod 32768
    initial begin
        int n;
        rst2_n = 1'b0; cen2 = 1'b0; keyon2 = 1'b0;
        #12;
        rst2_n = 1'b1;
        @(negedge clk);
        cen2 = 1'b1;
        n = 0;
        while (n < 65538) begin
            @(posedge clk);
            n++;
            #1;
            if (n >= 65533) begin
                check("wrap_slot",   slot2,   n % 2);
                check("wrap_eg_cnt", eg_cnt2, (n / 2) % 32768);
                check("wrap_zero",   zero2,   ((n % 2) == 0));
            end
        end
        cen2 = 1'b0;
        done2 = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/jtopl_eg_pipe.md
# jtopl_eg_pipe

Per-slot envelope state storage and sequencing for the OPL envelope generator. It holds the envelope phase, 10-bit attenuation and previous key state for every slot in a circular shift register. It presents the current slot's values, plus key edges and the global envelope counter, to the combinational envelope stages. It then writes the updated phase and attenuation back on each clock-enable tick. The block sits directly upstream and downstream of the envelope combinational pipeline: it feeds that pipeline and consumes its results.

## Interface
Parameters:
- SLOTS, 18, number of time-multiplexed operator slots (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cen  in  1  clock enable; one slot is processed per cycle with cen=1.
- keyon  in  1  key state of the slot currently at the head.
- state_next  in  3  next envelope phase from the envelope control stage.
- eg_next  in  10  next attenuation from the envelope arithmetic stage.
- keyon_now  out  1  key-on edge for the head slot.
- keyoff_now  out  1  key-off edge for the head slot.
- state_cur  out  3  stored phase of the head slot.
- eg_cur  out  10  stored attenuation of the head slot.
- slot  out  5  index of the head slot, 0..SLOTS-1.
- zero  out  1  high while slot==0.
- eg_cnt  out  15  global envelope counter.

## Operation
- Phase encoding is one-hot: ATTACK=3'b001, DECAY=3'b010, RELEASE=3'b100. The block stores state_next verbatim and does not validate it.
- Storage is a SLOTS-deep circular shift register. Each entry is {state[2:0], eg[9:0], kon_last}. The head entry drives state_cur, eg_cur and kon_last.
- Key edges are combinational from the head entry:
  - keyon_now = keyon & ~kon_last.
  - keyoff_now = ~keyon & kon_last.
- On a clk rising edge with cen=1:
  - All entries shift by one toward the head.
  - The tail entry is loaded with {state_next, eg_next, keyon}.
  - slot increments and wraps from SLOTS-1 to 0.
  - If slot==SLOTS-1 before the increment, eg_cnt increments by 1. It wraps from 15'h7FFF to 15'h0000.
- Consequence: a value written for slot k reappears at the head exactly SLOTS cen ticks later, again with slot==k.
- With cen=0, all registers hold. Outputs change only as the keyon input changes, through keyon_now and keyoff_now.
- There is no other write path. Phase changes originate solely from state_next.

## Timing
Reset (rst_n=0, asynchronous, takes effect immediately, regardless of clk and cen):
- Every entry is set to state=RELEASE, eg=10'h3FF and kon_last=0.
- slot=0, zero=1, eg_cnt=0.
- Output values during reset: keyon_now=keyon, keyoff_now=0, state_cur=3'b100, eg_cur=10'h3FF.

Reset release: the first cen=1 rising edge after rst_n goes high processes slot 0.

Reset mid-operation: all stored slot data is discarded. No partial write-back occurs on the reset edge.

Latency:
- state_cur, eg_cur, slot, zero and eg_cnt are register outputs, with zero combinational delay from clk.
- keyon_now and keyoff_now are combinational from keyon and the head register.
- state_next and eg_next must be valid by the same cen edge that retires the head slot. They are combinational functions of the current outputs.

Simultaneous events:
- keyon toggling on a slot whose entry is being written: the written kon_last is the keyon value sampled at that cen edge.
- The eg_cnt increment and the slot wrap happen on the same edge.
- eg_cnt wrap and slot wrap coinciding: eg_cnt=0 and slot=0 after the edge.

## Test plan
1. Reset values: assert rst_n=0 mid-cycle, with no clk edge. Required: immediately state_cur=3'b100, eg_cur=10'h3FF, slot=0, zero=1, eg_cnt=0, keyoff_now=0.
2. Key edge on one slot, SLOTS=18: drive keyon=1 only while slot==5, and loop state_next=3'b001 back when keyon_now=1.
   - Required: keyon_now=1 only on the first visit to slot 5.
   - On the next visit (18 cen later): kon_last=1, state_cur=3'b001, keyon_now=0.
   - Dropping keyon on the following visit gives keyoff_now=1 exactly once.
3. Write-back latency: write eg_next=10'h155 at slot 7 and 10'h2AA at slot 8, with other slots fed back unchanged. Required: eg_cur=10'h155 when slot==7 after 18 cen ticks, and 10'h2AA at slot 8, with no corruption of neighbouring slots.
4. Counter: run 18×5 cen ticks from reset. Required: eg_cnt=5, increments only on edges leaving slot 17, and zero high exactly 5 times plus the initial cycle. Force eg_cnt near 15'h7FFF via a long run or a bench hook. Required: wraps to 0 on the same edge as slot 17→0.
5. Clock enable: hold cen=0 for 100 clk cycles mid-sequence with changing state_next and eg_next. Required: slot, eg_cnt and all stored entries unchanged, and sequencing resumes from the same slot.
6. Reset mid-operation: after loading non-default values into all slots, pulse rst_n low for a fraction of a cycle. Required: every slot reads back RELEASE/10'h3FF/kon_last=0 over the next 18 cen ticks when fed back unchanged.
